// File: rtl/i_cache_line.sv
// Direct-mapped read-only instruction cache with multi-word lines and sequential line refill.
// Hits answer in the lookup cycle; misses refill one bus word at a time, then retry the lookup.
module i_cache_line #(
    parameter int A_WIDTH    = 32,
    parameter int C_INDEX    = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic [A_WIDTH-1:0] inst_paddr,
    input  logic [31:0]        excepttypeM,
    input  logic               inval_all,
    output logic [31:0]        instrF,
    output logic [A_WIDTH-1:0] IF_pc,
    output logic               i_data_ok,
    output logic               inst_req,
    output logic               inst_wr,
    output logic [1:0]         inst_size,
    output logic [A_WIDTH-1:0] inst_addr,
    output logic [31:0]        inst_wdata,
    input  logic [31:0]        inst_rdata,
    input  logic               inst_addr_ok,
    input  logic               inst_data_ok,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);
    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int KW    = (OFF > 0) ? OFF : 1;
    localparam int LINES = 1 << C_INDEX;
    localparam int TAG_W = A_WIDTH - C_INDEX - OFF - 2;
    localparam int DW    = C_INDEX + OFF;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [31:0]        data_mem [LINES*LINE_WORDS];
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   fill_tag;
    logic [C_INDEX-1:0] fill_index;
    logic [KW-1:0]      k;
    logic               kill;

    logic [TAG_W-1:0]   req_tag;
    logic [C_INDEX-1:0] req_index;
    logic [DW-1:0]      rd_ptr, wr_ptr;
    logic [A_WIDTH-1:0] fill_addr;
    logic               excepted, hit, start, fill_ok;
    logic               unused_bits;

    assign req_tag     = inst_paddr[A_WIDTH-1 -: TAG_W];
    assign req_index   = inst_paddr[OFF+2 +: C_INDEX];
    assign rd_ptr      = inst_paddr[2 +: DW];
    assign unused_bits = ^inst_paddr[1:0];

    generate
        if (OFF > 0) begin : g_multi
            assign wr_ptr    = {fill_index, k};
            assign fill_addr = {fill_tag, fill_index, k, 2'b00};
        end else begin : g_single
            assign wr_ptr    = fill_index;
            assign fill_addr = {fill_tag, fill_index, 2'b00};
        end
    endgenerate

    assign excepted = |excepttypeM;
    assign hit      = cpu_req && valid[req_index] && (tag_mem[req_index] == req_tag)
                      && (state == IDLE);
    assign start    = cpu_req && !hit && !excepted && (state == IDLE);
    // A kill or invalidate seen on the DONE cycle itself still blocks validation.
    assign fill_ok  = !kill && !excepted && !inval_all;

    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'h0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        inst_req  = 1'b0;
        inst_addr = '0;
        i_data_ok = 1'b0;
        instrF    = 32'h0;
        IF_pc     = '0;
        case (state)
            IDLE: begin
                if (hit && !excepted) begin
                    i_data_ok = 1'b1;
                    instrF    = data_mem[rd_ptr];
                    IF_pc     = inst_paddr;
                end else if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                inst_req  = 1'b1;
                inst_addr = fill_addr;
                if (inst_addr_ok) state_nxt = WAIT;
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (k == KW'(LINE_WORDS - 1)) state_nxt = DONE;
                    else                          state_nxt = REQ;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            kill     <= 1'b0;
            k        <= '0;
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (i_data_ok && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 32'd1;
            if (start) begin
                k <= '0;
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
            if (state == WAIT && inst_data_ok) k <= k + KW'(1);
            if (state == DONE)                                          kill <= 1'b0;
            else if (state != IDLE && (excepted || inval_all))          kill <= 1'b1;
            // The victim line goes invalid as soon as its words start being overwritten.
            if (inval_all) begin
                valid <= '0;
            end else begin
                if (start)                       valid[req_index]  <= 1'b0;
                if (state == DONE && fill_ok)    valid[fill_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            fill_tag   <= req_tag;
            fill_index <= req_index;
        end
        if (state == WAIT && inst_data_ok) data_mem[wr_ptr] <= inst_rdata;
        if (state == DONE)                 tag_mem[fill_index] <= fill_tag;
    end
endmodule

// File: tb/tb_i_cache_line.sv
// Bench for i_cache_line: behavioural bus slave plus per-scenario tasks checking responses,
// bus address order, latency and event counters against queued expectations.
module tb_i_cache_line;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] inst_paddr = 32'h0;
    logic [31:0] excepttypeM = 32'h0;
    logic        inval_all = 1'b0;
    logic [31:0] instrF, IF_pc;
    logic        i_data_ok, inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [31:0] inst_rdata = 32'h0;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    int addr_stall = 0;

    logic [31:0] got_addr_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];

    i_cache_line dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .inst_paddr(inst_paddr),
        .excepttypeM(excepttypeM), .inval_all(inval_all), .instrF(instrF), .IF_pc(IF_pc),
        .i_data_ok(i_data_ok), .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hC0DE_0000;
    endfunction

    // Bus slave: one outstanding transaction, data the cycle after address accept.
    logic        pending = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    initial forever begin
        @(negedge clk);
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else if (pending) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(pend_addr);
            pending      = 1'b0;
        end else if (inst_req) begin
            if (addr_stall > 0) begin
                addr_stall = addr_stall - 1;
            end else begin
                inst_addr_ok = 1'b1;
                pend_addr    = inst_addr;
                pending      = 1'b1;
                got_addr_q.push_back(inst_addr);
            end
        end
    end

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < LW; i++) exp_addr_q.push_back((a & ~32'hF) + 32'(4 * i));
    endtask

    task automatic check_bus(input string name);
        logic [31:0] e, g;
        checks++;
        if (got_addr_q.size() != exp_addr_q.size()) begin
            errors++;
            $display("FAIL %s bus_count got %0d want %0d", name, got_addr_q.size(), exp_addr_q.size());
        end
        while (got_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
            g = got_addr_q.pop_front();
            e = exp_addr_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s bus_addr got %h want %h", name, g, e);
            end
        end
        got_addr_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (hit_cnt !== 32'(exp_hit)) begin
            errors++;
            $display("FAIL %s hit_cnt got %0d want %0d", name, hit_cnt, exp_hit);
        end
        checks++;
        if (miss_cnt !== 32'(exp_miss)) begin
            errors++;
            $display("FAIL %s miss_cnt got %0d want %0d", name, miss_cnt, exp_miss);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input bit miss, input string name);
        int cyc;
        bit got;
        int lat;
        logic [31:0] ep, ei;
        if (miss) begin
            push_line(a);
            exp_miss++;
        end
        exp_pc_q.push_back(a);
        exp_ins_q.push_back(mem_word(a));
        cpu_req = 1'b1;
        inst_paddr = a;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 100) begin
            @(negedge clk); #1;
            if (i_data_ok) got = 1'b1;
            else cyc++;
        end
        ep = exp_pc_q.pop_front();
        ei = exp_ins_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s response timeout at %h", name, a);
        end else begin
            exp_hit++;
            checks++;
            if (IF_pc !== ep) begin
                errors++;
                $display("FAIL %s IF_pc got %h want %h", name, IF_pc, ep);
            end
            checks++;
            if (instrF !== ei) begin
                errors++;
                $display("FAIL %s instrF got %h want %h", name, instrF, ei);
            end
            lat = miss ? 2 * LW + 2 : 0;
            checks++;
            if (cyc != lat) begin
                errors++;
                $display("FAIL %s latency got %0d want %0d", name, cyc, lat);
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check_bus(name);
        check_counters(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({i_data_ok, inst_req, inst_wr} !== 3'b000 || instrF !== 32'h0 || IF_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ok=%b req=%b wr=%b ins=%h pc=%h want zeros",
                     i_data_ok, inst_req, inst_wr, instrF, IF_pc);
        end
        checks++;
        if (inst_size !== 2'b10 || inst_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_consts got size=%b wdata=%h want 10/0", inst_size, inst_wdata);
        end
        check_counters("reset");
    endtask

    task automatic test_cold_fill();
        fetch(32'h1000, 1'b1, "cold_fill");
    endtask

    task automatic test_line_hits();
        fetch(32'h1004, 1'b0, "hit_1004");
        fetch(32'h1008, 1'b0, "hit_1008");
        fetch(32'h100C, 1'b0, "hit_100c");
    endtask

    task automatic test_conflict();
        fetch(32'h1400, 1'b1, "conflict_1400");
        fetch(32'h1000, 1'b1, "conflict_1000");
    endtask

    task automatic test_kill();
        int n;
        bit resp;
        cpu_req = 1'b1;
        inst_paddr = 32'h1040;
        push_line(32'h1040);
        exp_miss++;
        resp = 1'b0;
        n = 0;
        while (got_addr_q.size() < 2 && n < 100) begin
            @(negedge clk); #1;
            resp |= i_data_ok;
            n++;
        end
        excepttypeM = 32'h4;
        n = 0;
        while (n < 20) begin
            @(negedge clk); #1;
            resp |= i_data_ok;
            n++;
        end
        checks++;
        if (resp) begin
            errors++;
            $display("FAIL kill_no_response got i_data_ok=1 want 0");
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        excepttypeM = 32'h0;
        check_bus("kill");
        check_counters("kill");
        fetch(32'h1040, 1'b1, "kill_refetch");
    endtask

    task automatic test_inval_all();
        fetch(32'h1080, 1'b1, "inval_fill_1080");
        inval_all = 1'b1;
        @(posedge clk); #1;
        inval_all = 1'b0;
        fetch(32'h1040, 1'b1, "inval_re_1040");
        fetch(32'h1080, 1'b1, "inval_re_1080");
        fetch(32'h1000, 1'b1, "inval_re_1000");
    endtask

    task automatic test_inval_in_wait();
        int n;
        cpu_req = 1'b1;
        inst_paddr = 32'h1100;
        push_line(32'h1100);
        push_line(32'h1100);
        exp_miss += 2;
        n = 0;
        while (got_addr_q.size() < 1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        inval_all = 1'b1;
        @(posedge clk); #1;
        inval_all = 1'b0;
        n = 0;
        while (!i_data_ok && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!i_data_ok || IF_pc !== 32'h1100 || instrF !== mem_word(32'h1100)) begin
            errors++;
            $display("FAIL inval_wait_resp got ok=%b pc=%h ins=%h want 1/%h/%h",
                     i_data_ok, IF_pc, instrF, 32'h1100, mem_word(32'h1100));
        end
        exp_hit++;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check_bus("inval_wait");
        check_counters("inval_wait");
    endtask

    task automatic test_addr_stall();
        int n;
        logic [31:0] a0;
        addr_stall = 5;
        cpu_req = 1'b1;
        inst_paddr = 32'h1200;
        push_line(32'h1200);
        exp_miss++;
        n = 0;
        while (!inst_req && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        a0 = inst_addr;
        checks++;
        if (!inst_req || a0 !== 32'h1200) begin
            errors++;
            $display("FAIL stall_first got req=%b addr=%h want 1/00001200", inst_req, a0);
        end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (inst_req !== 1'b1 || inst_addr !== a0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got req=%b addr=%h want 1/%h", i, inst_req, inst_addr, a0);
            end
        end
        n = 0;
        while (!i_data_ok && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!i_data_ok || IF_pc !== 32'h1200 || instrF !== mem_word(32'h1200)) begin
            errors++;
            $display("FAIL stall_resp got ok=%b pc=%h ins=%h", i_data_ok, IF_pc, instrF);
        end
        exp_hit++;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check_bus("stall");
        check_counters("stall");
    endtask

    task automatic test_back_to_back();
        fetch(32'h1204, 1'b0, "b2b_1204");
        fetch(32'h1208, 1'b0, "b2b_1208");
        fetch(32'h120C, 1'b0, "b2b_120c");
        fetch(32'h1200, 1'b0, "b2b_1200");
    endtask

    task automatic test_reset_in_wait();
        int n;
        cpu_req = 1'b1;
        inst_paddr = 32'h1300;
        n = 0;
        while (got_addr_q.size() < 1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        got_addr_q.delete();
        checks++;
        if ({i_data_ok, inst_req} !== 2'b00 || instrF !== 32'h0 || IF_pc !== 32'h0 || inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait_outputs got ok=%b req=%b ins=%h pc=%h addr=%h want zeros",
                     i_data_ok, inst_req, instrF, IF_pc, inst_addr);
        end
        check_counters("rst_wait");
        fetch(32'h1200, 1'b1, "rst_wait_refetch");
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_line_hits();
        test_conflict();
        test_kill();
        test_inval_all();
        test_inval_in_wait();
        test_addr_stall();
        test_back_to_back();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
